// File: rtl/mycpu_pkg.sv
// Shared types for the 16-bit CPU ALU: opcodes, flag bundle, FSM states and iteration constants.
package mycpu_pkg;

    localparam int ALU_DATA_W     = 16;
    localparam int ALU_ITER_STEPS = 16;

    typedef logic [ALU_DATA_W-1:0] alu_word_t;

    typedef enum logic [3:0] {
        OP_PASSA  = 4'h0,
        OP_ADD    = 4'h1,
        OP_SUB    = 4'h2,
        OP_AND    = 4'h3,
        OP_OR     = 4'h4,
        OP_XOR    = 4'h5,
        OP_NOT    = 4'h6,
        OP_SHL    = 4'h7,
        OP_SHR    = 4'h8,
        OP_ASR    = 4'h9,
        OP_MUL    = 4'hA,
        OP_DIV    = 4'hB,
        OP_PASSB  = 4'hC,
        OP_RSVD_D = 4'hD,
        OP_RSVD_E = 4'hE,
        OP_RSVD_F = 4'hF
    } alu_op_t;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } alu_flags_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result bundle between the register bank side (master) and the ALU (slave).
interface alu_seq_if;
    import mycpu_pkg::*;

    logic       start_in;
    alu_op_t    op_in;
    alu_word_t  a_in;
    alu_word_t  b_in;
    alu_word_t  d_out;
    logic       rw_out;
    logic       busy_out;
    alu_flags_t flags_out;

    modport master (
        output start_in, op_in, a_in, b_in,
        input  d_out, rw_out, busy_out, flags_out
    );

    modport slave (
        input  start_in, op_in, a_in, b_in,
        output d_out, rw_out, busy_out, flags_out
    );

endinterface

// File: rtl/alu_iter.sv
// Iterative shift-add multiplier (and restoring divider when MYCPU_ALU_DIV_EN is defined).
// lo_o holds product-low / quotient, hi_o holds product-high / remainder once last_o has fired.
module alu_iter
    import mycpu_pkg::*;
#(
    parameter int DATA_W     = ALU_DATA_W,
    parameter int ITER_STEPS = ALU_ITER_STEPS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
`ifdef MYCPU_ALU_DIV_EN
    input  logic              div_i,
`endif
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              last_o,
    output logic [DATA_W-1:0] lo_o,
    output logic [DATA_W-1:0] hi_o
);

    localparam int CNT_W = $clog2(ITER_STEPS + 1);

    logic              run_q, run_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [DATA_W:0]   mul_sum;
`ifdef MYCPU_ALU_DIV_EN
    logic              div_q, div_d;
    logic [DATA_W:0]   div_shift;
    logic [DATA_W:0]   div_trial;
`endif

    assign last_o = run_q && (cnt_q == CNT_W'(ITER_STEPS - 1));
    assign lo_o   = lo_q;
    assign hi_o   = hi_q;

    always_comb begin
        run_d = run_q;
        cnt_d = cnt_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        opb_d = opb_q;
        // Multiplier sits in lo and drains LSB-first while the product fills in from the top.
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
`ifdef MYCPU_ALU_DIV_EN
        div_d     = div_q;
        div_shift = {hi_q, lo_q[DATA_W-1]};
        div_trial = div_shift - {1'b0, opb_q};
`endif
        if (load_i) begin
            run_d = 1'b1;
            cnt_d = '0;
            hi_d  = '0;
            lo_d  = a_i;
            opb_d = b_i;
`ifdef MYCPU_ALU_DIV_EN
            div_d = div_i;
`endif
        end else if (run_q) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (last_o) run_d = 1'b0;
`ifdef MYCPU_ALU_DIV_EN
            if (div_q) begin
                if (!div_trial[DATA_W]) begin
                    hi_d = div_trial[DATA_W-1:0];
                    lo_d = {lo_q[DATA_W-2:0], 1'b1};
                end else begin
                    hi_d = div_shift[DATA_W-1:0];
                    lo_d = {lo_q[DATA_W-2:0], 1'b0};
                end
            end else
`endif
            begin
                hi_d = mul_sum[DATA_W:1];
                lo_d = {mul_sum[0], lo_q[DATA_W-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            opb_q <= '0;
`ifdef MYCPU_ALU_DIV_EN
            div_q <= 1'b0;
`endif
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            opb_q <= opb_d;
`ifdef MYCPU_ALU_DIV_EN
            div_q <= div_d;
`endif
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential 16-bit ALU: single-cycle ops plus iterative MUL (and DIV when MYCPU_ALU_DIV_EN
// is defined; otherwise opcode B behaves as reserved).
module alu_seq
    import mycpu_pkg::*;
#(
    parameter int DATA_W     = ALU_DATA_W,
    parameter int ITER_STEPS = ALU_ITER_STEPS
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_seq_if.slave  bus
);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] ITER = ST_ITER;
    localparam logic [1:0] DONE = ST_DONE;

    logic [1:0]             state_q, state_d;
    logic [DATA_W-1:0]      d_q, d_d;
    logic                   rw_q, rw_d;
    alu_flags_t             flags_q, flags_d;

    logic [DATA_W-1:0]      sc_res;
    logic                   sc_c, sc_v;
    logic [DATA_W:0]        wide;
    logic signed [DATA_W:0] asr_src;
    logic [3:0]             sh;
    logic                   accept, iter_load, iter_last;
    logic [DATA_W-1:0]      iter_lo, iter_hi;

    function automatic alu_flags_t flags_of(input logic [DATA_W-1:0] r, input logic c,
                                            input logic v);
        return '{z: (r == '0), n: r[DATA_W-1], c: c, v: v};
    endfunction

    always_comb begin
        sc_res  = '0;
        sc_c    = 1'b0;
        sc_v    = 1'b0;
        wide    = '0;
        asr_src = '0;
        sh      = bus.b_in[3:0];
        case (bus.op_in)
            OP_PASSA: sc_res = bus.a_in;
            OP_ADD: begin
                wide   = {1'b0, bus.a_in} + {1'b0, bus.b_in};
                sc_res = wide[DATA_W-1:0];
                sc_c   = wide[DATA_W];
                sc_v   = (bus.a_in[DATA_W-1] == bus.b_in[DATA_W-1]) &&
                         (sc_res[DATA_W-1] != bus.a_in[DATA_W-1]);
            end
            OP_SUB: begin
                wide   = {1'b0, bus.a_in} - {1'b0, bus.b_in};
                sc_res = wide[DATA_W-1:0];
                sc_c   = ~wide[DATA_W];
                sc_v   = (bus.a_in[DATA_W-1] != bus.b_in[DATA_W-1]) &&
                         (sc_res[DATA_W-1] != bus.a_in[DATA_W-1]);
            end
            OP_AND: sc_res = bus.a_in & bus.b_in;
            OP_OR:  sc_res = bus.a_in | bus.b_in;
            OP_XOR: sc_res = bus.a_in ^ bus.b_in;
            OP_NOT: sc_res = ~bus.a_in;
            // The extra bit beside the operand catches the last bit shifted out (0 for amount 0).
            OP_SHL: begin
                wide   = {1'b0, bus.a_in} << sh;
                sc_res = wide[DATA_W-1:0];
                sc_c   = wide[DATA_W];
            end
            OP_SHR: begin
                wide   = {bus.a_in, 1'b0} >> sh;
                sc_res = wide[DATA_W:1];
                sc_c   = wide[0];
            end
            OP_ASR: begin
                asr_src = {bus.a_in, 1'b0};
                wide    = asr_src >>> sh;
                sc_res  = wide[DATA_W:1];
                sc_c    = wide[0];
            end
`ifdef MYCPU_ALU_DIV_EN
            OP_DIV: begin
                sc_res = '1;
                sc_v   = 1'b1;
            end
`endif
            OP_PASSB: sc_res = bus.b_in;
            default:  sc_res = '0;
        endcase
    end

    assign accept    = bus.start_in && (state_q == IDLE);
    assign iter_load = accept && ((bus.op_in == OP_MUL)
`ifdef MYCPU_ALU_DIV_EN
                       || ((bus.op_in == OP_DIV) && (bus.b_in != '0))
`endif
                       );

    alu_iter #(
        .DATA_W     (DATA_W),
        .ITER_STEPS (ITER_STEPS)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (iter_load),
`ifdef MYCPU_ALU_DIV_EN
        .div_i  (bus.op_in == OP_DIV),
`endif
        .a_i    (bus.a_in),
        .b_i    (bus.b_in),
        .last_o (iter_last),
        .lo_o   (iter_lo),
        .hi_o   (iter_hi)
    );

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        flags_d = flags_q;
        rw_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (iter_load) begin
                    state_d = ITER;
                end else if (accept) begin
                    d_d     = sc_res;
                    flags_d = flags_of(sc_res, sc_c, sc_v);
                    rw_d    = 1'b1;
                end
            end
            ITER: if (iter_last) state_d = DONE;
            DONE: begin
                // Upper product half or remainder nonzero both map onto C.
                d_d     = iter_lo;
                flags_d = flags_of(iter_lo, |iter_hi, 1'b0);
                rw_d    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            d_q     <= '0;
            rw_q    <= 1'b0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            rw_q    <= rw_d;
            flags_q <= flags_d;
        end
    end

    assign bus.d_out     = d_q;
    assign bus.rw_out    = rw_q;
    assign bus.busy_out  = (state_q != IDLE);
    assign bus.flags_out = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vectors, MUL handshake, async reset abort,
// randomized ops against an integer reference model, and back-to-back streaming.
module tb_alu_seq;
    import mycpu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    alu_seq_if bus();

    alu_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] d;
        logic [3:0]  f;
        int          lat;
    } vec_t;

    // Reference model: integer arithmetic straight from the opcode table and flag rules.
    function automatic void model(input logic [3:0] op, input logic [15:0] a,
                                  input logic [15:0] b, output logic [15:0] r,
                                  output logic [3:0] f, output int lat);
        int ua, ub, sa, sb, sh, full, sd;
        longint p;
        logic c, v;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        sh = int'(b[3:0]);
        c = 1'b0; v = 1'b0; lat = 1; full = 0;
        case (op)
            4'h0: full = ua;
            4'h1: begin full = ua + ub; c = full > 65535; sd = sa + sb;
                        v = (sd > 32767) || (sd < -32768); end
            4'h2: begin full = ua - ub; c = ua >= ub; sd = sa - sb;
                        v = (sd > 32767) || (sd < -32768); end
            4'h3: full = ua & ub;
            4'h4: full = ua | ub;
            4'h5: full = ua ^ ub;
            4'h6: full = ~ua;
            4'h7: begin full = ua << sh; c = (sh != 0) && (((ua >> (16 - sh)) & 1) != 0); end
            4'h8: begin full = ua >> sh; c = (sh != 0) && (((ua >> (sh - 1)) & 1) != 0); end
            4'h9: begin full = sa >>> sh; c = (sh != 0) && (((sa >>> (sh - 1)) & 1) != 0); end
            4'hA: begin p = longint'(ua) * longint'(ub); full = int'(p % 65536);
                        c = p > 65535; lat = 18; end
`ifdef MYCPU_ALU_DIV_EN
            4'hB: begin
                if (ub == 0) begin full = 65535; v = 1'b1; end
                else begin full = ua / ub; c = (ua % ub) != 0; lat = 18; end
            end
`endif
            4'hC: full = ub;
            default: full = 0;
        endcase
        r = full[15:0];
        f = {r == 16'h0, r[15], c, v};
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] d, output logic [3:0] f, output int lat,
                          output int busy_n);
        @(negedge clk);
        bus.start_in = 1'b1;
        bus.op_in    = alu_op_t'(op);
        bus.a_in     = a;
        bus.b_in     = b;
        @(posedge clk);
        #1;
        bus.start_in = 1'b0;
        bus.a_in     = 16'($urandom);
        bus.b_in     = 16'($urandom);
        lat = 0; busy_n = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.busy_out) busy_n++;
            if (bus.rw_out) break;
        end
        d = bus.d_out;
        f = bus.flags_out;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start_in = 1'b0; bus.op_in = OP_PASSA; bus.a_in = 16'h1234; bus.b_in = 16'h5678;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.d_out !== 16'h0) begin errors++;
            $display("FAIL reset_d: got %h want 0000", bus.d_out); end
        checks++; if (bus.rw_out !== 1'b0) begin errors++;
            $display("FAIL reset_rw: got %b want 0", bus.rw_out); end
        checks++; if (bus.busy_out !== 1'b0) begin errors++;
            $display("FAIL reset_busy: got %b want 0", bus.busy_out); end
        checks++; if (bus.flags_out !== 4'h0) begin errors++;
            $display("FAIL reset_flags: got %b want 0000", bus.flags_out); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        vec_t vq[$];
        logic [15:0] d; logic [3:0] f; int lat, bn;
        vq.push_back('{op: 4'h1, a: 16'h7FFF, b: 16'h0001, d: 16'h8000, f: 4'b0101, lat: 1});
        vq.push_back('{op: 4'h2, a: 16'h0003, b: 16'h0005, d: 16'hFFFE, f: 4'b0100, lat: 1});
        vq.push_back('{op: 4'h2, a: 16'h0005, b: 16'h0005, d: 16'h0000, f: 4'b1010, lat: 1});
        vq.push_back('{op: 4'h9, a: 16'h8010, b: 16'h0004, d: 16'hF801, f: 4'b0100, lat: 1});
        vq.push_back('{op: 4'h7, a: 16'h8001, b: 16'h0001, d: 16'h0002, f: 4'b0010, lat: 1});
`ifdef MYCPU_ALU_DIV_EN
        vq.push_back('{op: 4'hB, a: 16'd100, b: 16'd7, d: 16'd14, f: 4'b0010, lat: 18});
        vq.push_back('{op: 4'hB, a: 16'd9, b: 16'd0, d: 16'hFFFF, f: 4'b0101, lat: 1});
`else
        vq.push_back('{op: 4'hB, a: 16'd100, b: 16'd7, d: 16'h0000, f: 4'b1000, lat: 1});
`endif
        vq.push_back('{op: 4'hE, a: 16'hFFFF, b: 16'hFFFF, d: 16'h0000, f: 4'b1000, lat: 1});
        foreach (vq[i]) begin
            run_op(vq[i].op, vq[i].a, vq[i].b, d, f, lat, bn);
            checks++; if (d !== vq[i].d) begin errors++;
                $display("FAIL dir%0d_d op %h: got %h want %h", i, vq[i].op, d, vq[i].d); end
            checks++; if (f !== vq[i].f) begin errors++;
                $display("FAIL dir%0d_flags op %h: got %b want %b", i, vq[i].op, f, vq[i].f); end
            checks++; if (lat !== vq[i].lat) begin errors++;
                $display("FAIL dir%0d_latency op %h: got %0d want %0d", i, vq[i].op, lat, vq[i].lat); end
            @(negedge clk);
            checks++; if (bus.rw_out !== 1'b0) begin errors++;
                $display("FAIL dir%0d_rw_pulse: rw still %b one cycle later, want 0", i, bus.rw_out); end
        end
    endtask

    task automatic test_mul_busy();
        int pulses = 0, first = 0, busy_n = 0;
        logic busy_at_done = 1'b0;
        logic [15:0] dg = '0; logic [3:0] fg = '0;
        @(negedge clk);
        bus.start_in = 1'b1; bus.op_in = OP_MUL; bus.a_in = 16'd300; bus.b_in = 16'd300;
        @(posedge clk);
        #1 bus.start_in = 1'b0;
        for (int n = 1; n <= 22; n++) begin
            @(negedge clk);
            if (bus.busy_out) busy_n++;
            if (n == 17) busy_at_done = bus.busy_out;
            if (bus.rw_out) begin
                pulses++;
                if (first == 0) begin first = n; dg = bus.d_out; fg = bus.flags_out; end
            end
            bus.a_in = 16'($urandom);
            bus.b_in = 16'($urandom);
            if (n == 5 || n == 17) begin bus.start_in = 1'b1; bus.op_in = OP_ADD; end
            else bus.start_in = 1'b0;
        end
        checks++; if (pulses !== 1) begin errors++;
            $display("FAIL mul_pulses: got %0d want 1", pulses); end
        checks++; if (first !== 18) begin errors++;
            $display("FAIL mul_latency: got %0d want 18", first); end
        checks++; if (busy_n !== 17) begin errors++;
            $display("FAIL mul_busy_cycles: got %0d want 17", busy_n); end
        checks++; if (busy_at_done !== 1'b1) begin errors++;
            $display("FAIL mul_busy_in_done: got %b want 1", busy_at_done); end
        checks++; if (dg !== 16'h5F90) begin errors++;
            $display("FAIL mul_d: got %h want 5f90", dg); end
        checks++; if (fg !== 4'b0010) begin errors++;
            $display("FAIL mul_flags: got %b want 0010", fg); end
        checks++; if (bus.d_out !== 16'h5F90) begin errors++;
            $display("FAIL mul_d_hold: got %h want 5f90", bus.d_out); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        logic [15:0] d; logic [3:0] f; int lat, bn;
        @(negedge clk);
        bus.start_in = 1'b1; bus.op_in = OP_MUL; bus.a_in = 16'd1234; bus.b_in = 16'd5678;
        @(posedge clk);
        #1 bus.start_in = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy_out !== 1'b0) begin errors++;
            $display("FAIL abort_busy: got %b want 0", bus.busy_out); end
        checks++; if (bus.d_out !== 16'h0) begin errors++;
            $display("FAIL abort_d: got %h want 0000", bus.d_out); end
        checks++; if (bus.flags_out !== 4'h0) begin errors++;
            $display("FAIL abort_flags: got %b want 0000", bus.flags_out); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) begin
            @(negedge clk);
            if (bus.rw_out) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++;
            $display("FAIL abort_no_rw: got %0d pulses want 0", pulses); end
        run_op(4'h1, 16'd2, 16'd3, d, f, lat, bn);
        checks++; if (d !== 16'd5) begin errors++;
            $display("FAIL abort_then_add: got %h want 0005", d); end
        checks++; if (lat !== 1) begin errors++;
            $display("FAIL abort_then_add_latency: got %0d want 1", lat); end
    endtask

    task automatic test_random();
        logic [3:0] op; logic [15:0] a, b, d, ed; logic [3:0] f, ef; int lat, elat, bn, ebn;
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 4))
                0: a = 16'h0000;
                1: a = 16'h7FFF;
                2: a = 16'h8000;
                3: a = 16'hFFFF;
                default: a = 16'($urandom);
            endcase
            b = 16'($urandom);
            if (i % 6 == 0) b = 16'h0000;
            else if (i % 6 == 1) b = 16'h0001 + 16'($urandom_range(0, 15));
            model(op, a, b, ed, ef, elat);
            ebn = (elat > 1) ? elat - 1 : 0;
            run_op(op, a, b, d, f, lat, bn);
            checks++; if (d !== ed) begin errors++;
                $display("FAIL rand%0d_d op %h a %h b %h: got %h want %h", i, op, a, b, d, ed); end
            checks++; if (f !== ef) begin errors++;
                $display("FAIL rand%0d_flags op %h a %h b %h: got %b want %b", i, op, a, b, f, ef); end
            checks++; if (lat !== elat) begin errors++;
                $display("FAIL rand%0d_latency op %h: got %0d want %0d", i, op, lat, elat); end
            checks++; if (bn !== ebn) begin errors++;
                $display("FAIL rand%0d_busy op %h: got %0d want %0d", i, op, bn, ebn); end
        end
    endtask

    task automatic test_back_to_back();
        vec_t q[$];
        vec_t v;
        int n = 16;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (i > 0) begin
                v = q.pop_front();
                checks++; if (bus.rw_out !== 1'b1) begin errors++;
                    $display("FAIL b2b%0d_rw: got %b want 1", i, bus.rw_out); end
                checks++; if (bus.d_out !== v.d) begin errors++;
                    $display("FAIL b2b%0d_d op %h: got %h want %h", i, v.op, bus.d_out, v.d); end
                checks++; if (bus.flags_out !== v.f) begin errors++;
                    $display("FAIL b2b%0d_flags op %h: got %b want %b", i, v.op, bus.flags_out, v.f); end
            end
            if (i < n) begin
                v.op = 4'($urandom_range(0, 15));
                if (v.op == 4'hA || v.op == 4'hB) v.op = 4'hC;
                v.a = 16'($urandom);
                v.b = 16'($urandom);
                model(v.op, v.a, v.b, v.d, v.f, v.lat);
                q.push_back(v);
                bus.start_in = 1'b1;
                bus.op_in    = alu_op_t'(v.op);
                bus.a_in     = v.a;
                bus.b_in     = v.b;
            end else begin
                bus.start_in = 1'b0;
            end
        end
        @(negedge clk);
        checks++; if (bus.rw_out !== 1'b0) begin errors++;
            $display("FAIL b2b_end_rw: got %b want 0", bus.rw_out); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mul_busy();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
